// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO register map,
// STATUS layout and reset values.
package dmem_pkg;

  localparam logic [31:0] DMEM_MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

  localparam logic [7:0] MMIO_OFF_GPIO   = 8'h00;
  localparam logic [7:0] MMIO_OFF_CYCLE  = 8'h04;
  localparam logic [7:0] MMIO_OFF_STATUS = 8'h08;

  localparam int unsigned STATUS_ERR_BIT = 0;
  localparam int unsigned STATUS_CNT_LSB = 16;

  localparam logic [31:0] RST_WORD  = 32'h0000_0000;
  localparam logic [15:0] RST_COUNT = 16'h0000;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/dmem_mmio_regs.sv
// Peripheral window registers (GPIO, free-running CYCLE counter, STATUS view)
// and their read mux; only instantiated when DMEM_MMIO_EN is defined.
module dmem_mmio_regs
  import dmem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [5:0]  woff_i,
  input  logic [31:0] wdata_i,
  input  logic [15:0] store_count_i,
  input  logic        misalign_err_i,
  output logic [31:0] rdata_o,
  output logic [31:0] gpio_o,
  output logic        reg_hit_o,
  output logic        status_clr_o
);

  logic [31:0] gpio_q, gpio_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] status_s;
  logic        hit_gpio_s, hit_cycle_s, hit_status_s;

  // Offset decode, read mux and next-state for the window registers
  always_comb begin
    hit_gpio_s   = (woff_i == MMIO_OFF_GPIO[7:2]);
    hit_cycle_s  = (woff_i == MMIO_OFF_CYCLE[7:2]);
    hit_status_s = (woff_i == MMIO_OFF_STATUS[7:2]);
    reg_hit_o    = hit_gpio_s | hit_cycle_s | hit_status_s;
    status_clr_o = we_i & hit_status_s;

    status_s = 32'h0000_0000;
    status_s[STATUS_CNT_LSB +: 16] = store_count_i;
    status_s[STATUS_ERR_BIT]       = misalign_err_i;

    case (woff_i)
      MMIO_OFF_GPIO[7:2]:   rdata_o = gpio_q;
      MMIO_OFF_CYCLE[7:2]:  rdata_o = cycle_q;
      MMIO_OFF_STATUS[7:2]: rdata_o = status_s;
      default:              rdata_o = 32'h0000_0000;
    endcase

    if (we_i && hit_gpio_s) begin
      gpio_d = wdata_i;
    end else begin
      gpio_d = gpio_q;
    end

    // A store to CYCLE replaces the value; counting resumes from it next edge
    if (we_i && hit_cycle_s) begin
      cycle_d = wdata_i;
    end else begin
      cycle_d = cycle_q + 32'd1;
    end
  end

  // Register state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gpio_q  <= RST_WORD;
      cycle_q <= RST_WORD;
    end else begin
      gpio_q  <= gpio_d;
      cycle_q <= cycle_d;
    end
  end

  assign gpio_o = gpio_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-cycle core data-memory responder: combinational-read word RAM,
// edge-write stores, sticky misalign flag, saturating store counter.
// Define DMEM_MMIO_EN to map GPIO/CYCLE/STATUS registers at MMIO_BASE.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] MMIO_BASE = DMEM_MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] gpio_out,
  output logic        misalign_err,
  output logic [15:0] store_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0] ram_q [DEPTH];
  logic [AW-1:0] idx_s;
  logic        aligned_s, mmio_hit_s, ram_we_s, mmio_we_s, store_done_s, misalign_s;
  logic        reg_hit_s, status_clr_s;
  logic [31:0] mmio_rdata_s;
  logic        misalign_err_q, misalign_err_d;
  logic [15:0] store_count_q, store_count_d;
  logic        unused_addr_s;

  assign idx_s         = ALUResult[AW+1:2];
  assign aligned_s     = (ALUResult[1:0] == 2'b00);
  assign unused_addr_s = ^ALUResult[31:AW+2];

`ifdef DMEM_MMIO_EN
  assign mmio_hit_s = (ALUResult[31:8] == MMIO_BASE[31:8]);

  dmem_mmio_regs u_mmio (
    .clk_i          (clk),
    .rst_ni         (reset),
    .we_i           (mmio_we_s),
    .woff_i         (ALUResult[7:2]),
    .wdata_i        (WriteData),
    .store_count_i  (store_count_q),
    .misalign_err_i (misalign_err_q),
    .rdata_o        (mmio_rdata_s),
    .gpio_o         (gpio_out),
    .reg_hit_o      (reg_hit_s),
    .status_clr_o   (status_clr_s)
  );
`else
  logic unused_base_s;
  assign unused_base_s = ^MMIO_BASE;
  assign mmio_hit_s    = 1'b0;
  assign mmio_rdata_s  = 32'h0000_0000;
  assign reg_hit_s     = 1'b0;
  assign status_clr_s  = 1'b0;
  assign gpio_out      = 32'h0000_0000;
`endif

  // Store qualification, read mux and flag/counter next-state
  always_comb begin
    ram_we_s     = MemWrite & aligned_s & ~mmio_hit_s;
    mmio_we_s    = MemWrite & aligned_s & mmio_hit_s;
    store_done_s = ram_we_s | (mmio_we_s & reg_hit_s);
    misalign_s   = MemWrite & ~aligned_s;

    if (mmio_hit_s) begin
      ReadData = mmio_rdata_s;
    end else begin
      ReadData = ram_q[idx_s];
    end

    // Setting the error takes priority over a STATUS clear
    if (misalign_s) begin
      misalign_err_d = 1'b1;
    end else if (status_clr_s) begin
      misalign_err_d = 1'b0;
    end else begin
      misalign_err_d = misalign_err_q;
    end

    if (store_done_s && (store_count_q != COUNT_MAX)) begin
      store_count_d = store_count_q + 16'd1;
    end else begin
      store_count_d = store_count_q;
    end
  end

  // RAM array, cleared on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram_q[i] <= RST_WORD;
      end
    end else if (ram_we_s) begin
      ram_q[idx_s] <= WriteData;
    end else begin
      ram_q[idx_s] <= ram_q[idx_s];
    end
  end

  // Sticky error flag and store counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_err_q <= 1'b0;
      store_count_q  <= RST_COUNT;
    end else begin
      misalign_err_q <= misalign_err_d;
      store_count_q  <= store_count_d;
    end
  end

  assign misalign_err = misalign_err_q;
  assign store_count  = store_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus queues expected outputs,
// a negedge monitor pops and compares. MMIO checks need DMEM_MMIO_EN.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [31:0] gpio_out;
  logic        misalign_err;
  logic [15:0] store_count;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          failures;
  logic [15:0] exp_sc;

  dmem_responder #(.DEPTH(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .ALUResult    (ALUResult),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .gpio_out     (gpio_out),
    .misalign_err (misalign_err),
    .store_count  (store_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    MemWrite  = we;
    ALUResult = a;
    WriteData = d;
  endtask

  task automatic expect_v(input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.sel  = sel;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every expectation queued during this cycle
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.sel)
          0:       act = ReadData;
          1:       act = {16'h0000, store_count};
          2:       act = {31'h0, misalign_err};
          default: act = gpio_out;
        endcase
        checks++;
        if (act !== e.val) begin
          failures++;
          $display("FAIL %s actual=%h expected=%h", e.name, act, e.val);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    exp_sc = 16'h0000;
    reset = 1'b0;
    MemWrite = 1'b0;
    ALUResult = 32'h0000_0010;
    WriteData = 32'h0;

    cyc(1'b1, 32'h0000_0010, 32'h1111_1111);
    expect_v(0, 32'h0, "rst_rd");
    expect_v(1, 32'h0, "rst_sc");
    expect_v(2, 32'h0, "rst_err");
    expect_v(3, 32'h0, "rst_gpio");

    @(posedge clk);
    #1;
    reset = 1'b1;
    MemWrite = 1'b0;
    ALUResult = 32'h0000_0010;
    expect_v(0, 32'h0, "post_rst_rd");

    cyc(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    cyc(1'b0, 32'h0000_0010, 32'h0);
    exp_sc = 16'd1;
    expect_v(0, 32'hDEAD_BEEF, "store_rd");
    expect_v(1, {16'h0, exp_sc}, "store_sc1");

    cyc(1'b1, 32'h0000_0100, 32'h0000_1234);
    cyc(1'b0, 32'h0000_0000, 32'h0);
    exp_sc = 16'd2;
    expect_v(0, 32'h0000_1234, "alias_rd");
    expect_v(1, {16'h0, exp_sc}, "alias_sc");

    cyc(1'b1, 32'h0000_0013, 32'h0000_0055);
    cyc(1'b0, 32'h0000_0013, 32'h0);
    expect_v(0, 32'hDEAD_BEEF, "misal_rd");
    expect_v(2, 32'h1, "misal_err");
    expect_v(1, {16'h0, exp_sc}, "misal_sc");

    cyc(1'b1, 32'hFFFF_FF08, 32'h0000_CAFE);
    cyc(1'b0, 32'hFFFF_FF08, 32'h0);
    exp_sc = 16'd3;
    expect_v(1, {16'h0, exp_sc}, "status_wr_sc");
`ifdef DMEM_MMIO_EN
    expect_v(2, 32'h0, "status_clr_err");
    expect_v(0, 32'h0003_0000, "status_rd");
    cyc(1'b0, 32'h0000_0008, 32'h0);
    expect_v(0, 32'h0, "status_ram_untouched");
`else
    expect_v(2, 32'h1, "alias_err_sticky");
    expect_v(0, 32'h0000_CAFE, "window_alias_rd");
    cyc(1'b0, 32'h0000_0008, 32'h0);
    expect_v(0, 32'h0000_CAFE, "window_alias_ram");
`endif

    cyc(1'b1, 32'h0000_0020, 32'h0000_0005);
    cyc(1'b1, 32'h0000_0020, 32'h0000_0007);
    exp_sc = 16'd4;
    expect_v(0, 32'h0000_0005, "rdw_old");
    expect_v(1, {16'h0, exp_sc}, "rdw_sc");
    cyc(1'b0, 32'h0000_0020, 32'h0);
    exp_sc = 16'd5;
    expect_v(0, 32'h0000_0007, "rdw_new");

    cyc(1'b1, 32'hFFFF_FF00, 32'h0000_00A5);
    cyc(1'b0, 32'h0000_0000, 32'h0);
    exp_sc = 16'd6;
    expect_v(1, {16'h0, exp_sc}, "gpio_sc");
`ifdef DMEM_MMIO_EN
    expect_v(3, 32'h0000_00A5, "gpio_out");
    expect_v(0, 32'h0000_1234, "gpio_ram_untouched");

    cyc(1'b1, 32'hFFFF_FF04, 32'hFFFF_FFFE);
    cyc(1'b0, 32'hFFFF_FF04, 32'h0);
    exp_sc = 16'd7;
    expect_v(0, 32'hFFFF_FFFE, "cycle_load");
    expect_v(1, {16'h0, exp_sc}, "cycle_sc");
    cyc(1'b0, 32'hFFFF_FF04, 32'h0);
    expect_v(0, 32'hFFFF_FFFF, "cycle_p1");
    cyc(1'b0, 32'hFFFF_FF04, 32'h0);
    expect_v(0, 32'h0000_0000, "cycle_wrap");
    cyc(1'b0, 32'hFFFF_FF04, 32'h0);
    expect_v(0, 32'h0000_0001, "cycle_p3");

    cyc(1'b1, 32'hFFFF_FF0C, 32'h0000_0077);
    cyc(1'b0, 32'hFFFF_FF0C, 32'h0);
    expect_v(0, 32'h0, "bad_off_rd");
    expect_v(1, {16'h0, exp_sc}, "bad_off_sc");
`else
    expect_v(3, 32'h0, "gpio_tied");
    expect_v(0, 32'h0000_00A5, "gpio_alias_ram");
`endif

    while (exp_sc != 16'hFFFF) begin
      cyc(1'b1, 32'h0000_0040, {16'h0, exp_sc});
      exp_sc = exp_sc + 16'd1;
    end
    cyc(1'b1, 32'h0000_0044, 32'h0000_BEEF);
    cyc(1'b0, 32'h0000_0044, 32'h0);
    expect_v(1, 32'h0000_FFFF, "sat_sc");
    expect_v(0, 32'h0000_BEEF, "sat_store_rd");

    cyc(1'b1, 32'h0000_0048, 32'h0000_0099);
    #2;
    reset = 1'b0;
    expect_v(0, 32'h0, "midrst_rd");
    expect_v(1, 32'h0, "midrst_sc");
    expect_v(2, 32'h0, "midrst_err");
    expect_v(3, 32'h0, "midrst_gpio");
    cyc(1'b1, 32'h0000_004C, 32'h0000_0011);
    expect_v(1, 32'h0, "inrst_sc");

    @(posedge clk);
    #1;
    reset = 1'b1;
    MemWrite = 1'b0;
    ALUResult = 32'h0000_0048;
    expect_v(0, 32'h0, "lost_store_rd");
    expect_v(1, 32'h0, "after_rst_sc");
    cyc(1'b0, 32'h0000_004C, 32'h0);
    expect_v(0, 32'h0, "inrst_store_rd");
    cyc(1'b0, 32'h0000_0010, 32'h0);
    expect_v(0, 32'h0, "after_rst_rd10");
    cyc(1'b0, 32'h0000_0044, 32'h0);
    expect_v(0, 32'h0, "after_rst_rd44");
    expect_v(2, 32'h0, "after_rst_err");
    expect_v(3, 32'h0, "after_rst_gpio");

    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() != 0) @(posedge clk);
    end
    @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
